// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, clock out
// 8 data bits + odd parity + stop on device clock falls, then check the ACK.
module ps2_host_tx #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int INHIBIT_US  = 120,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);
  localparam int INH_CYC = INHIBIT_US * (CLK_FREQ_HZ / 1_000_000);
  localparam int INH_W   = $clog2(INH_CYC + 1);
  localparam int TO_W    = $clog2(TIMEOUT_CYC + 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] INHIBIT   = 3'd1;
  localparam logic [2:0] RTS       = 3'd2;
  localparam logic [2:0] SHIFT     = 3'd3;
  localparam logic [2:0] ACK       = 3'd4;
  localparam logic [2:0] WAIT_IDLE = 3'd5;

  logic [2:0]      state;
  logic [2:0]      clk_s, dat_s;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [8:0]      sh;
  logic [3:0]      bidx;
  logic            ack_ok;
  logic            neg_edge;
  logic            clk_q, dat_q;

  // clk_s[0] is the first flop; data taken from the last stage of its chain
  assign neg_edge = clk_s[2] & ~clk_s[1];
  assign clk_q    = clk_s[1];
  assign dat_q    = dat_s[2];
  assign tx_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      clk_s       <= 3'b111;
      dat_s       <= 3'b111;
      inh_cnt     <= '0;
      to_cnt      <= '0;
      sh          <= '0;
      bidx        <= '0;
      ack_ok      <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
    end else begin
      clk_s   <= {clk_s[1:0], ps2_clk_i};
      dat_s   <= {dat_s[1:0], ps2_data_i};
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      case (state)
        IDLE: begin
          inh_cnt <= '0;
          to_cnt  <= '0;
          if (tx_valid) begin
            sh         <= {~^tx_data, tx_data};
            ps2_clk_oe <= 1'b1;
            state      <= INHIBIT;
          end
        end
        INHIBIT: begin
          to_cnt <= '0;
          if (inh_cnt == INH_W'(INH_CYC - 1)) begin
            ps2_data_oe <= 1'b1;
            state       <= RTS;
          end else begin
            inh_cnt <= inh_cnt + INH_W'(1);
          end
        end
        RTS: begin
          ps2_clk_oe <= 1'b0;
          to_cnt     <= '0;
          bidx       <= '0;
          state      <= SHIFT;
        end
        SHIFT, ACK, WAIT_IDLE: begin
          if (!neg_edge && to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_err      <= 1'b1;
            state       <= IDLE;
          end else begin
            to_cnt <= neg_edge ? '0 : to_cnt + TO_W'(1);
            case (state)
              SHIFT: if (neg_edge) begin
                if (bidx == 4'd9) begin
                  ps2_data_oe <= 1'b0;   // stop bit: release to pull-up
                  state       <= ACK;
                end else begin
                  ps2_data_oe <= ~sh[0];
                  sh          <= {1'b0, sh[8:1]};
                  bidx        <= bidx + 4'd1;
                end
              end
              ACK: if (neg_edge) begin
                ack_ok <= ~dat_q;
                state  <= WAIT_IDLE;
              end
              WAIT_IDLE: if (clk_q && dat_q) begin
                tx_done <= ack_ok;
                tx_err  <= ~ack_ok;
                state   <= IDLE;
              end
              default: ;
            endcase
          end
        end
        default: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a model PS/2 device on an open-drain bus, with a
// frame/result scoreboard fed from the stimulus side.
module tb_ps2_host_tx;
  localparam int CLK_HZ = 1_000_000;
  localparam int INH_US = 120;
  localparam int INH    = INH_US * (CLK_HZ / 1_000_000);
  localparam int TO     = 2000;
  localparam int HALF   = 20;

  logic clk = 1'b0, rst = 1'b1;
  logic tx_valid = 1'b0;
  logic [7:0] tx_data = '0;
  logic tx_ready, clk_oe, data_oe, busy, tx_done, tx_err;
  logic dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic clk_bus, data_bus;

  assign clk_bus  = ~(clk_oe | dev_clk_low);
  assign data_bus = ~(data_oe | dev_data_low);

  ps2_host_tx #(.CLK_FREQ_HZ(CLK_HZ), .INHIBIT_US(INH_US), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .ps2_clk_i(clk_bus), .ps2_data_i(data_bus), .ps2_clk_oe(clk_oe), .ps2_data_oe(data_oe),
    .busy(busy), .tx_done(tx_done), .tx_err(tx_err));

  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; logic par; } frame_t;
  frame_t frame_q[$];
  int     res_q[$];        // 0 = done, 1 = nack error, 2 = timeout error
  int checks = 0, failures = 0;
  int cyc = 0, last_edge_cyc = 0, dev_edges = 0, frames_seen = 0;
  int dev_stop = 0;
  bit dev_ack = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // odd parity: parity bit set when the byte holds an even number of ones
  function automatic logic odd_par(input logic [7:0] b);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(b[i]);
    return (n % 2 == 0);
  endfunction

  // model device
  initial begin : device
    int low_cnt, stop_at;
    bit ack, aborted;
    logic [9:0] bits;
    frame_t f;
    forever begin
      low_cnt = 0;
      forever begin
        @(negedge clk);
        if (!clk_bus) low_cnt++;
        else if (!data_bus && low_cnt > 0) break;
        else low_cnt = 0;
      end
      checks++;
      if (low_cnt < INH) begin
        failures++;
        $display("FAIL inhibit_len actual=%0d required>=%0d", low_cnt, INH);
      end
      stop_at = dev_stop; ack = dev_ack; aborted = 1'b0; bits = '0;
      for (int e = 1; e <= 11; e++) begin
        if (stop_at != 0 && e == stop_at + 1) begin aborted = 1'b1; break; end
        repeat (HALF / 2) @(negedge clk);
        if (e == 11) dev_data_low = ack;
        repeat (HALF / 2) @(negedge clk);
        dev_clk_low = 1'b1; dev_edges = e; last_edge_cyc = cyc;
        repeat (HALF) @(negedge clk);
        if (e <= 10) bits[e-1] = data_bus;
        dev_clk_low = 1'b0;
      end
      if (!aborted) begin
        repeat (HALF) @(negedge clk);
        dev_data_low = 1'b0;
        frames_seen++;
        if (frame_q.size() == 0) chk("unexpected_frame", 1, 0);
        else begin
          f = frame_q.pop_front();
          chk("frame_data", int'(bits[7:0]), int'(f.data));
          chk("frame_parity", int'(bits[8]), int'(f.par));
          chk("frame_stop", int'(bits[9]), 1);
        end
      end
      dev_edges = 0;
    end
  end

  // result monitor
  always @(negedge clk) begin : monitor
    int r, el;
    if (!rst && (tx_done || tx_err)) begin
      chk("done_err_exclusive", int'(tx_done && tx_err), 0);
      chk("ready_at_result", int'(tx_ready), 1);
      if (res_q.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        r = res_q.pop_front();
        chk("result_done", int'(tx_done), int'(r == 0));
        chk("result_err", int'(tx_err), int'(r != 0));
        if (r == 2) begin
          el = cyc - last_edge_cyc;
          chk("timeout_window", int'(el >= TO && el <= TO + 8), 1);
          chk("timeout_lines_released", int'({clk_oe, data_oe}), 0);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit ack, input int stop_at,
                      input int exp_res, input int hold);
    int n = 0;
    dev_ack = ack; dev_stop = stop_at;
    @(negedge clk); tx_valid = 1'b1; tx_data = b;
    while (!tx_ready && n < 10000) begin @(negedge clk); n++; end
    if (!tx_ready) begin
      chk("accept_timeout", 0, 1);
      tx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (exp_res == 0 || exp_res == 1) frame_q.push_back('{data: b, par: odd_par(b)});
    if (exp_res >= 0) res_q.push_back(exp_res);
    @(negedge clk);
    chk("accept_ready_low", int'(tx_ready), 0);
    chk("accept_busy", int'(busy), 1);
    chk("accept_clk_oe", int'(clk_oe), 1);
    repeat (hold) @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((busy || frame_q.size() != 0 || res_q.size() != 0) && n < 20000) begin
      @(negedge clk); n++;
    end
    chk("transfer_complete", int'(n < 20000), 1);
  endtask

  initial begin : stim
    int n, f0;
    logic [7:0] b;
    bit a;
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(tx_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_oe", int'({clk_oe, data_oe}), 0);
    chk("rst_pulses", int'({tx_done, tx_err}), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    send(8'hED, 1'b1, 0, 0, 0); wait_done();
    send(8'hF4, 1'b0, 0, 1, 0); wait_done();
    send(8'hA3, 1'b1, 4, 2, 0); wait_done();

    // reset mid-frame after the 6th device clock fall
    send(8'h1F, 1'b1, 6, -1, 0);
    n = 0;
    while (dev_edges != 6 && n < 5000) begin @(negedge clk); n++; end
    chk("reach_edge6", dev_edges, 6);
    repeat (8) @(negedge clk);
    chk("data_low_before_rst", int'(data_oe), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_clk_oe", int'(clk_oe), 0);
    chk("rst_mid_data_oe", int'(data_oe), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_ready", int'(tx_ready), 1);
    @(negedge clk); rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("rst_mid_idle", int'(busy), 0);

    // tx_valid held through a transfer: only one byte goes out
    f0 = frames_seen;
    send(8'h55, 1'b1, 0, 0, 300);
    wait_done();
    chk("held_valid_one_frame", frames_seen - f0, 1);

    // back to back
    f0 = frames_seen;
    send(8'hED, 1'b1, 0, 0, 0);
    send(8'h07, 1'b1, 0, 0, 0);
    wait_done();
    chk("b2b_frames", frames_seen - f0, 2);

    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255));
      a = ($urandom_range(0, 3) != 0);
      send(b, a, 0, a ? 0 : 1, 0);
      wait_done();
    end

    repeat (50) @(negedge clk);
    chk("final_queues_empty", frame_q.size() + res_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
